// File: rtl/signed_sat_accum.sv
// Two-stage signed accumulator: stage 1 captures the sample, stage 2 adds it to the
// running sum with overflow detection, optional clamping and overflow bookkeeping.
module signed_sat_accum #(
  parameter int WIDTH  = 8,
  parameter bit SAT_EN = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             acc_valid,
  output logic [WIDTH-1:0] acc,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             vld_q;
  logic             clr_q;
  logic [WIDTH-1:0] d_q;

  // Stage 1: unconditional capture, no backpressure.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      clr_q <= 1'b0;
      d_q   <= '0;
    end else begin
      vld_q <= in_valid;
      clr_q <= clear;
      d_q   <= in_data;
    end
  end

  logic [WIDTH-1:0] sum;
  logic             over;
  logic [WIDTH-1:0] acc_nxt;
  logic             ovf_nxt;
  logic             sticky_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             vld_nxt;

  // Overflow only when both operands share a sign and the modulo sum flips it.
  assign sum  = acc + d_q;
  assign over = (acc[MSB] == d_q[MSB]) && (sum[MSB] != acc[MSB]);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    acc_nxt    = acc;
    ovf_nxt    = 1'b0;
    sticky_nxt = ovf_sticky;
    cnt_nxt    = ovf_cnt;
    vld_nxt    = 1'b0;
    if (clr_q) begin
      acc_nxt    = vld_q ? d_q : '0;
      sticky_nxt = 1'b0;
      cnt_nxt    = '0;
      vld_nxt    = 1'b1;
    end else if (vld_q) begin
      if (over && SAT_EN) acc_nxt = acc[MSB] ? MIN_VAL : MAX_VAL;
      else                acc_nxt = sum;
      ovf_nxt    = over;
      sticky_nxt = ovf_sticky | over;
      if (over && (ovf_cnt != CNT_MAX)) cnt_nxt = ovf_cnt + 1'b1;
      vld_nxt    = 1'b1;
    end
  end

  // Stage 2: all outputs come straight from these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      acc_valid  <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      acc        <= acc_nxt;
      acc_valid  <= vld_nxt;
      ovf        <= ovf_nxt;
      ovf_sticky <= sticky_nxt;
      ovf_cnt    <= cnt_nxt;
    end
  end

endmodule
